// File: rtl/ifetch_unit.sv
// Multicycle instruction-fetch stage: PC register, memory request handshake,
// instruction register with field slicing, redirect/squash and fetch timeout.
module ifetch_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ADDR_W   = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_STEP  = XLEN'(4),
  parameter int unsigned     TIMEOUT  = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [31:0]       ir_out,
  output logic [XLEN-1:0]   ir_pc,
  output logic [6:0]        ir_opcode,
  output logic [4:0]        ir_rd,
  output logic [4:0]        ir_rs1,
  output logic [4:0]        ir_rs2,
  output logic              err_timeout,
  output logic              err_misalign
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_ERROR = 2'd2;

  logic [1:0]       state, state_n;
  logic             run;
  logic [XLEN-1:0]  pc, pc_n;
  logic [31:0]      ir_n;
  logic [XLEN-1:0]  ir_pc_n;
  logic [CNT_W-1:0] wait_cnt, wait_n, wait_inc;
  logic             err_timeout_n, err_misalign_n;

  // run holds the stage idle for the first edge after reset release, so the
  // request never depends combinationally on RESET.
  assign mem_req   = run && (state == S_FETCH);
  assign mem_addr  = pc[ADDR_W-1:0];
  assign ir_valid  = (state == S_HOLD);

  assign ir_opcode = ir_out[6:0];
  assign ir_rd     = ir_out[11:7];
  assign ir_rs1    = ir_out[19:15];
  assign ir_rs2    = ir_out[24:20];

  assign wait_inc  = wait_cnt + CNT_W'(1);

  always_comb begin
    state_n        = state;
    pc_n           = pc;
    ir_n           = ir_out;
    ir_pc_n        = ir_pc;
    wait_n         = wait_cnt;
    err_timeout_n  = err_timeout;
    err_misalign_n = err_misalign;

    if (run && (state != S_ERROR)) begin
      if (redirect_valid) begin
        // Redirect beats ack and ready; any data returned this cycle is dropped.
        if (redirect_pc[1:0] != 2'b00) begin
          err_misalign_n = 1'b1;
          state_n        = S_ERROR;
        end else begin
          pc_n    = redirect_pc;
          wait_n  = '0;
          state_n = S_FETCH;
        end
      end else if (state == S_FETCH) begin
        if (mem_ack) begin
          ir_n    = mem_rdata;
          ir_pc_n = pc;
          pc_n    = pc + PC_STEP;
          wait_n  = '0;
          state_n = S_HOLD;
        end else begin
          wait_n = wait_inc;
          if (wait_inc == CNT_W'(TIMEOUT)) begin
            err_timeout_n = 1'b1;
            state_n       = S_ERROR;
          end
        end
      end else if ((state == S_HOLD) && ir_ready) begin
        state_n = S_FETCH;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= S_FETCH;
      run          <= 1'b0;
      pc           <= RESET_PC;
      ir_out       <= '0;
      ir_pc        <= '0;
      wait_cnt     <= '0;
      err_timeout  <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      state        <= state_n;
      run          <= 1'b1;
      pc           <= pc_n;
      ir_out       <= ir_n;
      ir_pc        <= ir_pc_n;
      wait_cnt     <= wait_n;
      err_timeout  <= err_timeout_n;
      err_misalign <= err_misalign_n;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_ifetch_unit;

  localparam int unsigned TMO = 4;

  logic        CLK, RESET;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ir_valid, ir_ready;
  logic [31:0] ir_out;
  logic [63:0] ir_pc;
  logic [6:0]  ir_opcode;
  logic [4:0]  ir_rd, ir_rs1, ir_rs2;
  logic        err_timeout, err_misalign;

  ifetch_unit #(
    .XLEN(64), .ADDR_W(32), .RESET_PC(64'd0), .PC_STEP(64'd4), .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_out(ir_out), .ir_pc(ir_pc),
    .ir_opcode(ir_opcode), .ir_rd(ir_rd), .ir_rs1(ir_rs1), .ir_rs2(ir_rs2),
    .err_timeout(err_timeout), .err_misalign(err_misalign)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  // Behavioural model: what has been fetched, what is owed to the decoder.
  bit          m_run, m_err, m_have, m_tmo, m_mis;
  logic [63:0] m_pc, m_irpc;
  logic [31:0] m_ir;
  int unsigned m_wait;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    m_run = 0; m_err = 0; m_have = 0; m_tmo = 0; m_mis = 0;
    m_pc = 64'd0; m_irpc = 64'd0; m_ir = 32'd0; m_wait = 0;
  endtask

  task automatic model_step();
    if (RESET) return;
    if (!m_run) begin
      m_run = 1;
      return;
    end
    if (m_err) return;
    if (redirect_valid) begin
      if ((redirect_pc % 4) != 0) begin
        m_err = 1; m_mis = 1;
      end else begin
        m_pc = redirect_pc; m_have = 0; m_wait = 0;
      end
    end else if (!m_have) begin
      if (mem_ack) begin
        m_ir = mem_rdata; m_irpc = m_pc; m_pc = m_pc + 64'd4;
        m_have = 1; m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait == TMO) begin
          m_err = 1; m_tmo = 1;
        end
      end
    end else if (ir_ready) begin
      m_have = 0;
    end
  endtask

  // The single per-cycle compare against the model.
  always @(negedge CLK) begin
    if (check_en) begin
      chk("m_mem_req",  mem_req,  m_run && !m_err && !m_have);
      chk("m_mem_addr", mem_addr, m_pc & 64'hFFFF_FFFF);
      chk("m_ir_valid", ir_valid, m_have && !m_err);
      chk("m_ir_out",   ir_out,   m_ir);
      chk("m_ir_pc",    ir_pc,    m_irpc);
      chk("m_opcode",   ir_opcode, m_ir & 32'h7f);
      chk("m_rd",       ir_rd,    (m_ir / 128) % 32);
      chk("m_rs1",      ir_rs1,   (m_ir / 32768) % 32);
      chk("m_rs2",      ir_rs2,   (m_ir / 1048576) % 32);
      chk("m_err_tmo",  err_timeout,  m_tmo);
      chk("m_err_mis",  err_misalign, m_mis);
    end
  end

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    model_reset();
    #1;
    chk("rst_mem_req",  mem_req, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_ir_out",   ir_out, 0);
    chk("rst_ir_pc",    ir_pc, 0);
    chk("rst_err_tmo",  err_timeout, 0);
    chk("rst_err_mis",  err_misalign, 0);
    tick();
    tick();
    RESET = 1'b0;
    tick();
    chk("first_req",  mem_req, 1);
    chk("first_addr", mem_addr, 0);
  endtask

  int err_cycles;

  initial begin
    RESET = 1'b0; mem_ack = 1'b0; mem_rdata = '0; redirect_valid = 1'b0;
    redirect_pc = '0; ir_ready = 1'b0;
    #2;
    model_reset();
    check_en = 1'b1;
    apply_reset();

    // Back-to-back: ack and ready tied high.
    mem_ack = 1'b1; ir_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_rdata = $urandom;
      tick();
      if (i % 2 == 0) begin
        chk("b2b_valid", ir_valid, 1);
        chk("b2b_ir_pc", ir_pc, 64'(4 * (i / 2)));
      end else begin
        chk("b2b_req",  mem_req, 1);
        chk("b2b_addr", mem_addr, 32'(4 * ((i + 1) / 2)));
      end
    end

    // Ack delayed by three cycles at address 16.
    mem_ack = 1'b0; ir_ready = 1'b0; mem_rdata = 32'h00A2_8293;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dly_req",  mem_req, 1);
      chk("dly_addr", mem_addr, 32'd16);
    end
    mem_ack = 1'b1;
    tick();
    chk("dly_valid",  ir_valid, 1);
    chk("dly_ir_out", ir_out, 32'h00A2_8293);
    chk("dly_opcode", ir_opcode, 7'h13);
    chk("dly_rd",     ir_rd, 5);
    chk("dly_rs1",    ir_rs1, 5);
    chk("dly_rs2",    ir_rs2, 10);
    chk("dly_ir_pc",  ir_pc, 64'd16);

    // Decoder stalls in HOLD.
    ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ack = 1'($urandom);
      mem_rdata = $urandom;
      tick();
      chk("stall_valid",  ir_valid, 1);
      chk("stall_req",    mem_req, 0);
      chk("stall_ir_out", ir_out, 32'h00A2_8293);
    end
    ir_ready = 1'b1; mem_ack = 1'b0;
    tick();
    chk("rel_valid", ir_valid, 0);
    chk("rel_addr",  mem_addr, 32'd20);
    ir_ready = 1'b0;

    // Redirect in the same cycle as ack squashes the data.
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    tick();
    chk("sq_valid",  ir_valid, 0);
    chk("sq_addr",   mem_addr, 32'h100);
    chk("sq_ir_out", ir_out, 32'h00A2_8293);
    chk("sq_ir_pc",  ir_pc, 64'd16);
    redirect_valid = 1'b0; mem_rdata = 32'h0000_0013;
    tick();
    chk("post_sq_ir_pc", ir_pc, 64'h100);
    ir_ready = 1'b1; mem_ack = 1'b0;
    tick();
    chk("post_sq_addr", mem_addr, 32'h104);

    // PC wraps past the top of the address space.
    ir_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    chk("top_addr", mem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0; mem_ack = 1'b1;
    tick();
    chk("wrap_ir_pc", ir_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    ir_ready = 1'b1; mem_ack = 1'b0;
    tick();
    chk("wrap_addr", mem_addr, 32'd0);
    chk("wrap_req",  mem_req, 1);

    // Misaligned redirect locks the stage in error.
    ir_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h102;
    tick();
    chk("mis_flag",  err_misalign, 1);
    chk("mis_req",   mem_req, 0);
    chk("mis_addr",  mem_addr, 32'd0);
    redirect_valid = 1'b0; mem_ack = 1'b1; ir_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err_hold_req",   mem_req, 0);
      chk("err_hold_valid", ir_valid, 0);
    end
    mem_ack = 1'b0; ir_ready = 1'b0;
    apply_reset();

    // Fetch timeout after TMO cycles without ack.
    for (int k = 1; k <= int'(TMO); k++) begin
      tick();
      if (k < int'(TMO)) begin
        chk("tmo_req_pre", mem_req, 1);
        chk("tmo_flag_pre", err_timeout, 0);
      end else begin
        chk("tmo_flag", err_timeout, 1);
        chk("tmo_req",  mem_req, 0);
      end
    end
    apply_reset();

    // Randomized traffic.
    err_cycles = 0;
    for (int i = 0; i < 500; i++) begin
      mem_ack   = ($urandom_range(0, 9) < 6);
      mem_rdata = $urandom;
      ir_ready  = 1'($urandom);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = {$urandom, $urandom} & ~64'd3;
      if ($urandom_range(0, 7) == 0)
        redirect_pc = redirect_pc | 64'($urandom_range(1, 3));
      tick();
      if (m_err) err_cycles++;
      if (err_cycles > 3) begin
        err_cycles = 0;
        redirect_valid = 1'b0;
        apply_reset();
      end
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
